// File: rtl/store_buffer_if.sv
// Store buffer port bundle: MEM-stage stores/loads and the memory write port.
// The master side drives stores, loads and mem_busy; the slave is the buffer.
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int DW    = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          st_valid;
  logic [AW-1:0] st_adr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_adr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_busy;
  logic          memWrite;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output st_valid, st_adr, st_data,
    output ld_valid, ld_adr, mem_busy,
    input  st_ready, ld_hit, ld_data,
    input  memWrite, mem_adr, mem_wdata,
    input  count, empty
  );

  modport slave (
    input  st_valid, st_adr, st_data,
    input  ld_valid, ld_adr, mem_busy,
    output st_ready, ld_hit, ld_data,
    output memWrite, mem_adr, mem_wdata,
    output count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer between MEM stage and data memory write port,
// with youngest-match load forwarding from buffered stores.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int DW    = 16
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    adr_q [DEPTH];
  logic [DW-1:0]    dat_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;
  logic             empty;

  assign empty = (cnt == '0);
  assign push  = sb.st_valid & sb.st_ready;
  assign pop   = ~empty & ~sb.mem_busy;

  assign sb.st_ready  = (cnt != CW'(DEPTH));
  assign sb.empty     = empty;
  assign sb.count     = cnt;
  assign sb.memWrite  = pop;
  assign sb.mem_adr   = empty ? '0 : adr_q[rd_ptr];
  assign sb.mem_wdata = empty ? '0 : dat_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      vld_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + PW'(1);
        vld_q[wr_ptr]  <= 1'b1;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + PW'(1);
        vld_q[rd_ptr]  <= 1'b0;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      adr_q[wr_ptr] <= sb.st_adr;
      dat_q[wr_ptr] <= sb.st_data;
    end
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    sb.ld_hit  = 1'b0;
    sb.ld_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (sb.ld_valid && vld_q[idx] &&
          adr_q[idx] == sb.ld_adr) begin
        sb.ld_hit  = 1'b1;
        sb.ld_data = dat_q[idx];
      end
    end
  end
endmodule
